morse_keyer_ctrl: RTL and testbench

MORSE_KEYER_CTRL -- requirements
Module: morse_keyer_ctrl

---
 rtl/morse_pkg.sv | 17 +
 rtl/morse_debounce.sv | 63 ++++++
 rtl/morse_keyer_ctrl.sv | 159 +++++++++++++++
 tb/tb_morse_keyer_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared encodings and FSM state type for the Morse keyer controller.
package morse_pkg;

    localparam logic [1:0] DOT  = 2'b01;
    localparam logic [1:0] DASH = 2'b11;

    localparam logic [9:0] CODE_BLANK = 10'h001;
    localparam logic [9:0] CODE_ERR   = 10'h003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        SPACE = 2'd3
    } state_t;

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser and debouncer for the raw key.
// Produces the debounced level, edge pulses, and a "settled" flag for a level that has been stable for a full window.
module morse_debounce #(
    parameter int DB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_settled
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_diff_cnt;
    logic [CW-1:0] r_same_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_diff_cnt <= '0;
            r_same_cnt <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 != r_level) begin
                r_same_cnt <= '0;
                if (r_diff_cnt == CW'(DB_CYC - 1)) begin
                    r_level    <= r_sync2;
                    r_rise     <= r_sync2;
                    r_fall     <= ~r_sync2;
                    r_diff_cnt <= '0;
                end else begin
                    r_diff_cnt <= r_diff_cnt + 1'b1;
                end
            end else begin
                r_diff_cnt <= '0;
                if (r_same_cnt != CW'(DB_CYC))
                    r_same_cnt <= r_same_cnt + 1'b1;
            end
        end
    end

    assign o_level   = r_level;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_settled = (r_same_cnt == CW'(DB_CYC));

endmodule

// File: rtl/morse_keyer_ctrl.sv
// Morse keyer: times debounced presses and gaps, assembles up to four symbols into a code word,
// and strobes letters, word spaces and clears to the downstream seven-segment decoder.
module morse_keyer_ctrl
    import morse_pkg::*;
#(
    parameter int DB_CYC   = 1_000_000,
    parameter int DASH_CYC = 30_000_000,
    parameter int LGAP_CYC = 60_000_000,
    parameter int WGAP_CYC = 140_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    input  logic       clr,
    output logic [9:0] code_out,
    output logic       code_vld,
    output logic [2:0] sym_cnt,
    output logic       key_led
);

    localparam int PW = $clog2(DASH_CYC + 1);
    localparam int GW = $clog2(WGAP_CYC + 1);

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_press_cnt, w_press_nxt;
    logic [GW-1:0] r_gap_cnt, w_gap_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [2:0]    r_sym_cnt, w_sym_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic          r_arm, w_arm_nxt;
    logic [9:0]    r_code, w_code_nxt;
    logic          r_vld, w_vld_nxt;

    logic       w_level, w_rise, w_fall, w_settled;
    logic       w_press_go;
    logic [1:0] w_sym;

    morse_debounce #(.DB_CYC(DB_CYC)) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_key    (key_in),
        .o_level  (w_level),
        .o_rise   (w_rise),
        .o_fall   (w_fall),
        .o_settled(w_settled)
    );

    // A key held through reset stays unarmed until it has been seen released.
    assign w_arm_nxt  = r_arm | w_fall | (~w_level & w_settled);
    assign w_press_go = w_rise & r_arm;
    assign w_sym      = (r_press_cnt >= PW'(DASH_CYC)) ? DASH : DOT;

    // NOTE: every variable gets a default before the branches so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_press_nxt = r_press_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_shift_nxt = r_shift;
        w_sym_nxt   = r_sym_cnt;
        w_ovf_nxt   = r_ovf;
        w_code_nxt  = r_code;
        w_vld_nxt   = 1'b0;

        if (clr) begin
            w_code_nxt  = CODE_BLANK;
            w_vld_nxt   = 1'b1;
            w_sym_nxt   = '0;
            w_shift_nxt = '0;
            w_ovf_nxt   = 1'b0;
            w_press_nxt = '0;
            w_gap_nxt   = '0;
            w_state_nxt = (w_level && r_arm) ? PRESS : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_press_go) begin
                        w_state_nxt = PRESS;
                        w_press_nxt = '0;
                    end
                end
                PRESS: begin
                    if (r_press_cnt != PW'(DASH_CYC))
                        w_press_nxt = r_press_cnt + 1'b1;
                    if (w_fall) begin
                        if (r_sym_cnt < 3'd4) begin
                            w_shift_nxt = r_shift | (8'(w_sym) << {r_sym_cnt[1:0], 1'b0});
                            w_sym_nxt   = r_sym_cnt + 3'd1;
                        end else begin
                            w_ovf_nxt = 1'b1;
                            w_sym_nxt = 3'd5;
                        end
                        w_gap_nxt   = '0;
                        w_state_nxt = GAP;
                    end
                end
                GAP: begin
                    if (r_gap_cnt != GW'(WGAP_CYC))
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    if (r_gap_cnt >= GW'(LGAP_CYC)) begin
                        w_code_nxt  = r_ovf ? CODE_ERR : {r_shift, 2'b00};
                        w_vld_nxt   = 1'b1;
                        w_sym_nxt   = '0;
                        w_shift_nxt = '0;
                        w_ovf_nxt   = 1'b0;
                        w_gap_nxt   = '0;
                        w_press_nxt = '0;
                        w_state_nxt = w_press_go ? PRESS : SPACE;
                    end else if (w_press_go) begin
                        w_press_nxt = '0;
                        w_state_nxt = PRESS;
                    end
                end
                SPACE: begin
                    if (r_gap_cnt != GW'(WGAP_CYC))
                        w_gap_nxt = r_gap_cnt + 1'b1;
                    if (w_press_go) begin
                        w_press_nxt = '0;
                        w_state_nxt = PRESS;
                    end else if (r_gap_cnt >= GW'(WGAP_CYC)) begin
                        w_code_nxt  = CODE_BLANK;
                        w_vld_nxt   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_press_cnt <= '0;
            r_gap_cnt   <= '0;
            r_shift     <= '0;
            r_sym_cnt   <= '0;
            r_ovf       <= 1'b0;
            r_arm       <= 1'b0;
            r_code      <= CODE_BLANK;
            r_vld       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_press_cnt <= w_press_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_shift     <= w_shift_nxt;
            r_sym_cnt   <= w_sym_nxt;
            r_ovf       <= w_ovf_nxt;
            r_arm       <= w_arm_nxt;
            r_code      <= w_code_nxt;
            r_vld       <= w_vld_nxt;
        end
    end

    assign code_out = r_code;
    assign code_vld = r_vld;
    assign sym_cnt  = r_sym_cnt;
    assign key_led  = w_level;

endmodule

// File: tb/tb_morse_keyer_ctrl.sv
// Directed bench for morse_keyer_ctrl with short timing parameters.
// A negedge monitor logs every strobe; scenario tasks compare against hand-derived values.
module tb_morse_keyer_ctrl;

    localparam int DB   = 4;
    localparam int DASH = 20;
    localparam int LGAP = 40;
    localparam int WGAP = 100;

    localparam logic [9:0] C_E     = 10'b0000000100;
    localparam logic [9:0] C_A     = 10'b0000110100;
    localparam logic [9:0] C_T     = 10'b0000001100;
    localparam logic [9:0] C_BLANK = 10'h001;
    localparam logic [9:0] C_ERR   = 10'h003;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_in;
    logic       clr;
    logic [9:0] code_out;
    logic       code_vld;
    logic [2:0] sym_cnt;
    logic       key_led;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_dbl   = 0;
    logic prev_vld = 1'b0;
    logic [9:0] q_code[$];
    int         q_cyc[$];

    always #5 clk = ~clk;

    morse_keyer_ctrl #(
        .DB_CYC  (DB),
        .DASH_CYC(DASH),
        .LGAP_CYC(LGAP),
        .WGAP_CYC(WGAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key_in),
        .clr     (clr),
        .code_out(code_out),
        .code_vld(code_vld),
        .sym_cnt (sym_cnt),
        .key_led (key_led)
    );

    always @(negedge clk) begin
        cyc++;
        if (!rst && code_vld) begin
            q_code.push_back(code_out);
            q_cyc.push_back(cyc);
        end
        if (code_vld && prev_vld) n_dbl++;
        prev_vld = code_vld;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        q_code.delete();
        q_cyc.delete();
    endtask

    function automatic int n_letters();
        int n = 0;
        foreach (q_code[i]) if (q_code[i] != C_BLANK) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; key_in = 1'b0; clr = 1'b0;
        tick(4);
        n_tests++;
        if (code_out !== C_BLANK) begin n_fail++; $display("FAIL reset_code: got %h want %h", code_out, C_BLANK); end
        n_tests++;
        if (code_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", code_vld); end
        n_tests++;
        if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_sym: got %0d want 0", sym_cnt); end
        n_tests++;
        if (key_led !== 1'b0) begin n_fail++; $display("FAIL reset_led: got %b want 0", key_led); end
        rst = 1'b0;
        tick(12);
        n_tests++;
        if (q_code.size() != 0) begin n_fail++; $display("FAIL reset_quiet: got %0d strobes want 0", q_code.size()); end
        clear_log();
    endtask

    task automatic test_letter_e();
        clear_log();
        key_in = 1'b1; tick(8);
        n_tests++;
        if (key_led !== 1'b1) begin n_fail++; $display("FAIL e_led_on: got %b want 1", key_led); end
        tick(2); key_in = 1'b0; tick(20);
        n_tests++;
        if (sym_cnt !== 3'd1) begin n_fail++; $display("FAIL e_sym: got %0d want 1", sym_cnt); end
        n_tests++;
        if (key_led !== 1'b0) begin n_fail++; $display("FAIL e_led_off: got %b want 0", key_led); end
        tick(40);
        n_tests++;
        if (q_code.size() != 1 || q_code[0] !== C_E) begin
            n_fail++; $display("FAIL e_code: got %0d strobes first %h want 1 strobe %h", q_code.size(), (q_code.size() > 0) ? q_code[0] : 10'hx, C_E);
        end
        tick(120);
        n_tests++;
        if (q_code.size() != 2 || q_code[1] !== C_BLANK) begin
            n_fail++; $display("FAIL e_space: got %0d strobes last %h want 2 strobes ending %h", q_code.size(), (q_code.size() > 1) ? q_code[1] : 10'hx, C_BLANK);
        end
        n_tests++;
        if (q_code.size() < 2 || q_cyc[1] - q_cyc[0] != WGAP + 1) begin
            n_fail++; $display("FAIL e_space_delay: got %0d cycles want %0d", (q_code.size() > 1) ? q_cyc[1] - q_cyc[0] : -1, WGAP + 1);
        end
        clear_log();
    endtask

    task automatic test_letter_a();
        clear_log();
        key_in = 1'b1; tick(10); key_in = 1'b0; tick(10);
        key_in = 1'b1; tick(30); key_in = 1'b0; tick(20);
        n_tests++;
        if (sym_cnt !== 3'd2) begin n_fail++; $display("FAIL a_sym: got %0d want 2", sym_cnt); end
        tick(40);
        n_tests++;
        if (q_code.size() != 1 || q_code[0] !== C_A) begin
            n_fail++; $display("FAIL a_code: got %0d strobes first %h want 1 strobe %h", q_code.size(), (q_code.size() > 0) ? q_code[0] : 10'hx, C_A);
        end
        n_tests++;
        if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL a_sym_clr: got %0d want 0", sym_cnt); end
        tick(120);
        clear_log();
    endtask

    task automatic test_overflow();
        clear_log();
        for (int i = 0; i < 6; i++) begin
            key_in = 1'b1; tick(10); key_in = 1'b0;
            if (i < 5) tick(10);
        end
        tick(20);
        n_tests++;
        if (sym_cnt !== 3'd5) begin n_fail++; $display("FAIL ovf_sym: got %0d want 5", sym_cnt); end
        tick(40);
        n_tests++;
        if (q_code.size() != 1 || q_code[0] !== C_ERR) begin
            n_fail++; $display("FAIL ovf_code: got %0d strobes first %h want 1 strobe %h", q_code.size(), (q_code.size() > 0) ? q_code[0] : 10'hx, C_ERR);
        end
        n_tests++;
        if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL ovf_sym_clr: got %0d want 0", sym_cnt); end
        tick(120);
        clear_log();
    endtask

    task automatic test_bounce();
        int led_hi = 0;
        clear_log();
        for (int i = 0; i < 25; i++) begin
            key_in = ~key_in;
            tick(1); if (key_led) led_hi++;
            tick(1); if (key_led) led_hi++;
        end
        key_in = 1'b0;
        tick(60);
        n_tests++;
        if (led_hi != 0) begin n_fail++; $display("FAIL bounce_led: got %0d high cycles want 0", led_hi); end
        n_tests++;
        if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL bounce_sym: got %0d want 0", sym_cnt); end
        n_tests++;
        if (q_code.size() != 0) begin n_fail++; $display("FAIL bounce_strobe: got %0d strobes want 0", q_code.size()); end
        clear_log();
    endtask

    // clr lands on the exact edge where the gap count reaches LGAP.
    task automatic test_clr_gap();
        clear_log();
        key_in = 1'b1; tick(10); key_in = 1'b0; tick(10);
        key_in = 1'b1; tick(10); key_in = 1'b0;
        tick(47);
        n_tests++;
        if (sym_cnt !== 3'd2) begin n_fail++; $display("FAIL clr_pre_sym: got %0d want 2", sym_cnt); end
        clr = 1'b1; tick(1); clr = 1'b0;
        n_tests++;
        if (code_vld !== 1'b1 || code_out !== C_BLANK) begin
            n_fail++; $display("FAIL clr_out: got vld %b code %h want vld 1 code %h", code_vld, code_out, C_BLANK);
        end
        n_tests++;
        if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL clr_sym: got %0d want 0", sym_cnt); end
        tick(150);
        n_tests++;
        if (n_letters() != 0 || q_code.size() != 1) begin
            n_fail++; $display("FAIL clr_strobes: got %0d letters %0d strobes want 0 letters 1 strobe", n_letters(), q_code.size());
        end
        clear_log();
    endtask

    task automatic test_reset_mid();
        clear_log();
        key_in = 1'b1; tick(10); key_in = 1'b0; tick(20);
        rst = 1'b1; tick(2); rst = 1'b0;
        tick(160);
        n_tests++;
        if (q_code.size() != 0) begin n_fail++; $display("FAIL rstmid_strobe: got %0d strobes want 0", q_code.size()); end
        n_tests++;
        if (code_out !== C_BLANK || sym_cnt !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_state: got code %h sym %0d want %h 0", code_out, sym_cnt, C_BLANK);
        end
        clear_log();
    endtask

    task automatic test_held_reset();
        clear_log();
        key_in = 1'b1; rst = 1'b1; tick(4); rst = 1'b0;
        tick(20);
        n_tests++;
        if (key_led !== 1'b1) begin n_fail++; $display("FAIL held_led: got %b want 1", key_led); end
        key_in = 1'b0; tick(20);
        n_tests++;
        if (sym_cnt !== 3'd0) begin n_fail++; $display("FAIL held_no_sym: got %0d want 0", sym_cnt); end
        key_in = 1'b1; tick(30); key_in = 1'b0; tick(20);
        n_tests++;
        if (sym_cnt !== 3'd1) begin n_fail++; $display("FAIL held_sym: got %0d want 1", sym_cnt); end
        tick(40);
        n_tests++;
        if (q_code.size() != 1 || q_code[0] !== C_T) begin
            n_fail++; $display("FAIL held_code: got %0d strobes first %h want 1 strobe %h", q_code.size(), (q_code.size() > 0) ? q_code[0] : 10'hx, C_T);
        end
        tick(120);
        clear_log();
    endtask

    initial begin
        test_reset();
        test_letter_e();
        test_letter_a();
        test_overflow();
        test_bounce();
        test_clr_gap();
        test_reset_mid();
        test_held_reset();
        n_tests++;
        if (n_dbl != 0) begin n_fail++; $display("FAIL double_strobe: got %0d want 0", n_dbl); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
